// File: rtl/timing_engine_seq_if.sv
// Handshake bundle between the radio timing-engine sequencer and its surroundings.
// Master drives requests and the far-end acknowledge; slave is the sequencer.
interface timing_engine_seq_if;
  logic       isolate;
  logic       radio_en_req;
  logic       rx_mode;
  logic       radio_en_ack;
  logic       err_clr;
  logic       pll_en;
  logic       pll_settled;
  logic       tarst_fs;
  logic       busy;
  logic       err;
  logic [2:0] state_o;

  modport master (
    output isolate, radio_en_req, rx_mode, radio_en_ack, err_clr,
    input  pll_en, pll_settled, tarst_fs, busy, err, state_o
  );

  modport slave (
    input  isolate, radio_en_req, rx_mode, radio_en_ack, err_clr,
    output pll_en, pll_settled, tarst_fs, busy, err, state_o
  );
endinterface

// File: rtl/timing_engine_seq.sv
// Radio timing-engine sequencer: PLL power-up, settle, far-end acknowledge handshake,
// guard delay, RX enable and ordered shutdown, with isolation clamping.
//
// state    | meaning
// IDLE     | radio off, waiting for a request
// PLL_ON   | PLL powered, settle timer running
// WAIT_ACK | pll_settled raised, waiting for the far-end acknowledge
// GUARD    | acknowledge seen, guard timer running
// ACTIVE   | radio running (tarst_fs high for RX sessions)
// SHUTDOWN | pll_settled dropped, waiting for the acknowledge to fall
module timing_engine_seq #(
  parameter int SETTLE_CYCLES = 64,
  parameter int GUARD_CYCLES  = 4,
  parameter int ACK_TIMEOUT   = 255,
  parameter int CNT_W         = 8
) (
  input logic               ck,
  input logic               arst,
  timing_engine_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PLL_ON   = 3'd1,
    S_WAIT_ACK = 3'd2,
    S_GUARD    = 3'd3,
    S_ACTIVE   = 3'd4,
    S_SHUTDOWN = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LD  = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LD    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_rx;
  logic             r_pll_en;
  logic             r_pll_settled;
  logic             r_tarst;

  state_t           w_nxt_state;
  logic [CNT_W-1:0] w_nxt_cnt;
  logic [CNT_W-1:0] w_cnt_dec;
  logic             w_cnt_zero;
  logic             w_set_err;
  logic             w_nxt_rx;
  logic             w_pll_en_d;
  logic             w_pll_settled_d;
  logic             w_tarst_d;

  assign w_cnt_zero = (r_cnt == '0);
  // Saturating decrement: the timer never wraps below zero.
  assign w_cnt_dec  = w_cnt_zero ? r_cnt : r_cnt - CNT_ONE;

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_err         <= 1'b0;
      r_rx          <= 1'b0;
      r_pll_en      <= 1'b0;
      r_pll_settled <= 1'b0;
      r_tarst       <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_cnt         <= w_nxt_cnt;
      r_err         <= w_set_err | (r_err & ~bus.err_clr);
      r_rx          <= w_nxt_rx;
      r_pll_en      <= w_pll_en_d;
      r_pll_settled <= w_pll_settled_d;
      r_tarst       <= w_tarst_d;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_set_err   = 1'b0;
    w_nxt_rx    = r_rx;
    if (bus.isolate) begin
      w_nxt_state = S_IDLE;
      w_nxt_cnt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.radio_en_req) begin
            w_nxt_rx    = bus.rx_mode;
            w_nxt_cnt   = SETTLE_LD;
            w_nxt_state = S_PLL_ON;
          end
        end
        S_PLL_ON: begin
          if (!bus.radio_en_req) begin
            w_nxt_state = S_IDLE;
          end else if (w_cnt_zero) begin
            w_nxt_state = S_WAIT_ACK;
            w_nxt_cnt   = ACK_LD;
          end else begin
            w_nxt_cnt   = w_cnt_dec;
          end
        end
        S_WAIT_ACK: begin
          if (!bus.radio_en_req) begin
            w_nxt_state = S_SHUTDOWN;
            w_nxt_cnt   = ACK_LD;
          end else if (bus.radio_en_ack) begin
            w_nxt_state = S_GUARD;
            w_nxt_cnt   = GUARD_LD;
          end else if (w_cnt_zero) begin
            w_set_err   = 1'b1;
            w_nxt_state = S_IDLE;
          end else begin
            w_nxt_cnt   = w_cnt_dec;
          end
        end
        S_GUARD: begin
          if (!bus.radio_en_req || !bus.radio_en_ack) begin
            w_set_err   = bus.radio_en_req;
            w_nxt_state = S_SHUTDOWN;
            w_nxt_cnt   = ACK_LD;
          end else if (w_cnt_zero) begin
            w_nxt_state = S_ACTIVE;
          end else begin
            w_nxt_cnt   = w_cnt_dec;
          end
        end
        S_ACTIVE: begin
          if (!bus.radio_en_req || !bus.radio_en_ack) begin
            w_set_err   = bus.radio_en_req;
            w_nxt_state = S_SHUTDOWN;
            w_nxt_cnt   = ACK_LD;
          end
        end
        S_SHUTDOWN: begin
          if (!bus.radio_en_ack) begin
            w_nxt_state = S_IDLE;
          end else if (w_cnt_zero) begin
            w_set_err   = 1'b1;
            w_nxt_state = S_IDLE;
          end else begin
            w_nxt_cnt   = w_cnt_dec;
          end
        end
        default: begin
          w_nxt_state = S_IDLE;
          w_nxt_cnt   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_pll_en_d      = 1'b0;
    w_pll_settled_d = 1'b0;
    w_tarst_d       = 1'b0;
    case (w_nxt_state)
      S_PLL_ON, S_SHUTDOWN: w_pll_en_d = 1'b1;
      S_WAIT_ACK, S_GUARD: begin
        w_pll_en_d      = 1'b1;
        w_pll_settled_d = 1'b1;
      end
      S_ACTIVE: begin
        w_pll_en_d      = 1'b1;
        w_pll_settled_d = 1'b1;
        w_tarst_d       = w_nxt_rx;
      end
      default: ;
    endcase
  end

  // Isolation clamps the power-domain crossing outputs without waiting for an edge.
  assign bus.pll_en      = r_pll_en & ~bus.isolate;
  assign bus.pll_settled = r_pll_settled & ~bus.isolate;
  assign bus.tarst_fs    = r_tarst & ~bus.isolate;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.err         = r_err;
  assign bus.state_o     = r_state;

endmodule

// File: tb/tb_timing_engine_seq.sv
// Self-checking bench for timing_engine_seq: directed scenarios plus a randomized run
// checked against an edge-count based reference model.
module tb_timing_engine_seq;
  localparam int S = 8;
  localparam int G = 2;
  localparam int T = 16;
  localparam int W = 8;

  localparam int M_IDLE   = 0;
  localparam int M_PLL    = 1;
  localparam int M_WAIT   = 2;
  localparam int M_GUARD  = 3;
  localparam int M_ACTIVE = 4;
  localparam int M_SHUT   = 5;

  logic ck = 1'b0;
  logic arst = 1'b1;
  int   total = 0;
  int   bad = 0;

  timing_engine_seq_if tif();

  timing_engine_seq #(
    .SETTLE_CYCLES(S),
    .GUARD_CYCLES (G),
    .ACK_TIMEOUT  (T),
    .CNT_W        (W)
  ) dut (
    .ck  (ck),
    .arst(arst),
    .bus (tif)
  );

  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  function automatic logic [7:0] pack(input logic pe, input logic ps, input logic tf,
                                      input logic bz, input logic er, input int st);
    return {pe, ps, tf, bz, er, 3'(st)};
  endfunction

  function automatic logic [7:0] outs();
    return {tif.pll_en, tif.pll_settled, tif.tarst_fs, tif.busy, tif.err, tif.state_o};
  endfunction

  task automatic idle_inputs();
    tif.isolate      = 1'b0;
    tif.radio_en_req = 1'b0;
    tif.rx_mode      = 1'b0;
    tif.radio_en_ack = 1'b0;
    tif.err_clr      = 1'b0;
  endtask

  task automatic bring_up(input logic rx);
    tif.radio_en_req = 1'b1;
    tif.rx_mode      = rx;
    tif.radio_en_ack = 1'b0;
    repeat (S + 1) tick();
    tif.radio_en_ack = 1'b1;
    repeat (G + 1) tick();
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    idle_inputs();
    arst = 1'b1;
    #2;
    exp = pack(0, 0, 0, 0, 0, M_IDLE);
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=%b", outs(), exp);
    end
    tick();
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL reset_held got=%b want=%b", outs(), exp);
    end
    arst = 1'b0;
  endtask

  task automatic test_session(input logic rx);
    logic [7:0] exp;
    int a;
    tif.radio_en_req = 1'b1;
    tif.rx_mode      = rx;
    tif.radio_en_ack = 1'b0;
    tick();
    exp = pack(1, 0, 0, 1, 0, M_PLL);
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL session_e0 rx=%b got=%b want=%b", rx, outs(), exp);
    end
    for (int k = 1; k <= S + 1; k++) begin
      tick();
      exp = (k < S) ? pack(1, 0, 0, 1, 0, M_PLL) : pack(1, 1, 0, 1, 0, M_WAIT);
      total++;
      if (outs() !== exp) begin
        bad++;
        $display("FAIL session_settle rx=%b edge=%0d got=%b want=%b", rx, k, outs(), exp);
      end
    end
    tif.radio_en_ack = 1'b1;
    a = S + 2;
    for (int k = a; k <= a + G; k++) begin
      tick();
      exp = (k < a + G) ? pack(1, 1, 0, 1, 0, M_GUARD) : pack(1, 1, rx, 1, 0, M_ACTIVE);
      total++;
      if (outs() !== exp) begin
        bad++;
        $display("FAIL session_guard rx=%b edge=%0d got=%b want=%b", rx, k, outs(), exp);
      end
    end
  endtask

  task automatic test_shutdown();
    logic [7:0] exp;
    tif.radio_en_req = 1'b0;
    exp = pack(1, 0, 0, 1, 0, M_SHUT);
    for (int k = 0; k <= 3; k++) begin
      tick();
      total++;
      if (outs() !== exp) begin
        bad++;
        $display("FAIL shutdown_hold edge=D+%0d got=%b want=%b", k, outs(), exp);
      end
    end
    tif.radio_en_ack = 1'b0;
    tick();
    exp = pack(0, 0, 0, 0, 0, M_IDLE);
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL shutdown_done got=%b want=%b", outs(), exp);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] exp;
    tif.radio_en_req = 1'b1;
    tif.rx_mode      = 1'b1;
    tif.radio_en_ack = 1'b0;
    repeat (S + 1) tick();
    for (int j = 1; j <= T; j++) begin
      tick();
      exp = (j < T) ? pack(1, 1, 0, 1, 0, M_WAIT) : pack(0, 0, 0, 0, 1, M_IDLE);
      total++;
      if (outs() !== exp) begin
        bad++;
        $display("FAIL timeout_wait edge=%0d got=%b want=%b", j, outs(), exp);
      end
    end
    tif.radio_en_req = 1'b0;
    tick();
    exp = pack(0, 0, 0, 0, 1, M_IDLE);
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL timeout_sticky got=%b want=%b", outs(), exp);
    end
    tif.err_clr = 1'b1;
    tick();
    tif.err_clr = 1'b0;
    exp = pack(0, 0, 0, 0, 0, M_IDLE);
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL timeout_clear got=%b want=%b", outs(), exp);
    end
  endtask

  task automatic test_ack_loss();
    logic [7:0] exp;
    bring_up(1'b1);
    tif.radio_en_ack = 1'b0;
    tick();
    exp = pack(1, 0, 0, 1, 1, M_SHUT);
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL ack_loss_shutdown got=%b want=%b", outs(), exp);
    end
    tick();
    tif.radio_en_req = 1'b0;
    exp = pack(0, 0, 0, 0, 1, M_IDLE);
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL ack_loss_idle got=%b want=%b", outs(), exp);
    end
  endtask

  task automatic test_isolate();
    logic [7:0] exp;
    bring_up(1'b1);
    tif.isolate = 1'b1;
    #1;
    exp = pack(0, 0, 0, 1, 1, M_ACTIVE);
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL isolate_clamp got=%b want=%b", outs(), exp);
    end
    exp = pack(0, 0, 0, 0, 1, M_IDLE);
    for (int k = 0; k < 2; k++) begin
      tick();
      total++;
      if (outs() !== exp) begin
        bad++;
        $display("FAIL isolate_idle edge=%0d got=%b want=%b", k, outs(), exp);
      end
    end
    idle_inputs();
    tif.err_clr = 1'b1;
    tick();
    tif.err_clr = 1'b0;
    exp = pack(0, 0, 0, 0, 0, M_IDLE);
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL isolate_release got=%b want=%b", outs(), exp);
    end
  endtask

  task automatic test_arst();
    logic [7:0] exp;
    tif.radio_en_req = 1'b1;
    tif.rx_mode      = 1'b1;
    tif.radio_en_ack = 1'b0;
    repeat (5) tick();
    exp = pack(1, 0, 0, 1, 0, M_PLL);
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL arst_pre got=%b want=%b", outs(), exp);
    end
    arst = 1'b1;
    #1;
    exp = pack(0, 0, 0, 0, 0, M_IDLE);
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL arst_async got=%b want=%b", outs(), exp);
    end
    tick();
    arst = 1'b0;
    tick();
    for (int k = 1; k <= S; k++) begin
      tick();
      exp = (k < S) ? pack(1, 0, 0, 1, 0, M_PLL) : pack(1, 1, 0, 1, 0, M_WAIT);
      total++;
      if (outs() !== exp) begin
        bad++;
        $display("FAIL arst_resettle edge=%0d got=%b want=%b", k, outs(), exp);
      end
    end
    tif.radio_en_req = 1'b0;
    repeat (2) tick();
    exp = pack(0, 0, 0, 0, 0, M_IDLE);
    total++;
    if (outs() !== exp) begin
      bad++;
      $display("FAIL arst_cleanup got=%b want=%b", outs(), exp);
    end
  endtask

  // Reference model: states move on absolute edge deadlines rather than a down-counter.
  task automatic test_random();
    int   m_st, m_dl, n, stuck_left;
    logic m_rx, m_err, stuck_val, se;
    logic req, iso, rx, ack, clr;
    logic [7:0] exp;
    idle_inputs();
    arst = 1'b1;
    tick();
    arst = 1'b0;
    m_st = M_IDLE; m_dl = 0; n = 0; m_rx = 1'b0; m_err = 1'b0;
    stuck_left = 0; stuck_val = 1'b0; req = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) req = ~req;
      iso = ($urandom_range(0, 99) == 0);
      clr = ($urandom_range(0, 29) == 0);
      rx  = 1'($urandom_range(0, 1));
      if (stuck_left > 0) begin
        ack = stuck_val;
        stuck_left--;
      end else if ($urandom_range(0, 59) == 0) begin
        stuck_left = $urandom_range(5, 40);
        stuck_val  = 1'($urandom_range(0, 1));
        ack        = stuck_val;
      end else begin
        ack = tif.pll_settled;
        if ($urandom_range(0, 99) == 0) ack = ~ack;
      end
      tif.radio_en_req = req;
      tif.isolate      = iso;
      tif.rx_mode      = rx;
      tif.radio_en_ack = ack;
      tif.err_clr      = clr;
      #1;
      exp = pack((m_st != M_IDLE) && !iso,
                 (m_st == M_WAIT || m_st == M_GUARD || m_st == M_ACTIVE) && !iso,
                 (m_st == M_ACTIVE) && m_rx && !iso,
                 m_st != M_IDLE, m_err, m_st);
      total++;
      if (outs() !== exp) begin
        bad++;
        $display("FAIL random cycle=%0d got=%b want=%b", c, outs(), exp);
      end
      @(posedge ck);
      n++;
      se = 1'b0;
      if (iso) m_st = M_IDLE;
      else begin
        case (m_st)
          M_IDLE: if (req) begin m_rx = rx; m_st = M_PLL; m_dl = n + S; end
          M_PLL: begin
            if (!req) m_st = M_IDLE;
            else if (n == m_dl) begin m_st = M_WAIT; m_dl = n + T; end
          end
          M_WAIT: begin
            if (!req) begin m_st = M_SHUT; m_dl = n + T; end
            else if (ack) begin m_st = M_GUARD; m_dl = n + G; end
            else if (n == m_dl) begin se = 1'b1; m_st = M_IDLE; end
          end
          M_GUARD, M_ACTIVE: begin
            if (!req) begin m_st = M_SHUT; m_dl = n + T; end
            else if (!ack) begin se = 1'b1; m_st = M_SHUT; m_dl = n + T; end
            else if (m_st == M_GUARD && n == m_dl) m_st = M_ACTIVE;
          end
          default: begin
            if (!ack) m_st = M_IDLE;
            else if (n == m_dl) begin se = 1'b1; m_st = M_IDLE; end
          end
        endcase
      end
      m_err = se | (m_err & !clr);
      #1;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_session(1'b1);
    test_shutdown();
    test_session(1'b0);
    test_shutdown();
    test_timeout();
    test_ack_loss();
    test_isolate();
    test_arst();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
